// File: rtl/req_order_queue.sv
// First-come-first-served ordering queue in front of the 4-requester grant arbiter.
// Optional macro REQ_WITHDRAW_EN drops queued entries whose raw request falls low.
module req_order_queue (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] raw_req,
    input  logic       pop,
    output logic       head_valid,
    output logic [1:0] head_id,
    output logic [3:0] head_req,
    output logic [3:0] pending,
    output logic [2:0] count
);

    logic [3:0] prev_req;
    logic [1:0] slot [4];

    logic [3:0] arr;
    logic [1:0] nxt_slot [4];
    logic [2:0] nxt_count;
    logic [3:0] nxt_pending;
`ifdef REQ_WITHDRAW_EN
    logic [1:0] pre_slot [4];
    logic [2:0] pre_count;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latches).
    always_comb begin
        // Arrivals are qualified against the pre-update pending set, so a
        // requester popped on this same edge cannot re-enter.
        arr       = raw_req & ~prev_req & ~pending;
        nxt_slot  = slot;
        nxt_count = count;

        if (pop && (count != 3'd0)) begin
            for (int k = 0; k < 3; k++) begin
                nxt_slot[k] = nxt_slot[k+1];
            end
            nxt_slot[3] = 2'b00;
            nxt_count   = nxt_count - 3'd1;
        end

`ifdef REQ_WITHDRAW_EN
        pre_slot  = nxt_slot;
        pre_count = nxt_count;
        nxt_count = 3'd0;
        for (int k = 0; k < 4; k++) begin
            nxt_slot[k] = 2'b00;
        end
        for (int k = 0; k < 4; k++) begin
            if ((3'(k) < pre_count) && raw_req[pre_slot[k]]) begin
                nxt_slot[nxt_count[1:0]] = pre_slot[k];
                nxt_count                = nxt_count + 3'd1;
            end
        end
`endif

        for (int i = 0; i < 4; i++) begin
            if (arr[i] && (nxt_count < 3'd4)) begin
                nxt_slot[nxt_count[1:0]] = 2'(i);
                nxt_count                = nxt_count + 3'd1;
            end
        end

        nxt_pending = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < nxt_count) begin
                nxt_pending[nxt_slot[k]] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: the slot array is small and must read 0 when unused, so it is reset like any other register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_req <= 4'b0000;
            pending  <= 4'b0000;
            count    <= 3'd0;
            for (int k = 0; k < 4; k++) begin
                slot[k] <= 2'b00;
            end
        end else begin
            prev_req <= raw_req;
            pending  <= nxt_pending;
            count    <= nxt_count;
            for (int k = 0; k < 4; k++) begin
                slot[k] <= nxt_slot[k];
            end
        end
    end

    // Unused slots hold 0, so slot[0] already reads 0 when the queue is empty.
    assign head_valid = (count != 3'd0);
    assign head_id    = slot[0];
    assign head_req   = head_valid ? (4'b0001 << slot[0]) : 4'b0000;

endmodule

// File: tb/tb_req_order_queue.sv
// Self-checking bench for req_order_queue: hand-derived vector table, corner
// sequences, then random traffic against a queue-based reference model.
module tb_req_order_queue;

    logic       clk;
    logic       resetn;
    logic [3:0] raw_req;
    logic       pop;
    logic       head_valid;
    logic [1:0] head_id;
    logic [3:0] head_req;
    logic [3:0] pending;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    req_order_queue dut (
        .clk        (clk),
        .resetn     (resetn),
        .raw_req    (raw_req),
        .pop        (pop),
        .head_valid (head_valid),
        .head_id    (head_id),
        .head_req   (head_req),
        .pending    (pending),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] raw;
        logic       pop;
        logic [2:0] cnt;
        logic [1:0] hid;
        logic [3:0] pend;
    } vec_t;

    vec_t tbl[$];

    // Reference model: the queue holds requester IDs oldest first.
    int         mq[$];
    logic [3:0] mprev;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic step(input logic [3:0] r, input logic p);
        raw_req = r;
        pop     = p;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [2:0] c, input logic [1:0] h,
                               input logic [3:0] pd);
        check({tag, " count"},      int'(count),      int'(c));
        check({tag, " head_valid"}, int'(head_valid), (c != 0) ? 1 : 0);
        check({tag, " head_id"},    int'(head_id),    (c != 0) ? int'(h) : 0);
        check({tag, " head_req"},   int'(head_req),   (c != 0) ? (1 << h) : 0);
        check({tag, " pending"},    int'(pending),    int'(pd));
    endtask

    function automatic logic [3:0] model_pending();
        logic [3:0] pd = 4'b0000;
        foreach (mq[k]) pd[mq[k]] = 1'b1;
        return pd;
    endfunction

    task automatic model_reset();
        mq.delete();
        mprev = 4'b0000;
    endtask

    task automatic model_step(input logic [3:0] r, input logic p);
        logic [3:0] arr;
        arr = r & ~mprev & ~model_pending();
        if (p && (mq.size() > 0)) void'(mq.pop_front());
`ifdef REQ_WITHDRAW_EN
        begin
            int keep[$];
            foreach (mq[k]) if (r[mq[k]]) keep.push_back(mq[k]);
            mq = keep;
        end
`endif
        for (int i = 0; i < 4; i++) if (arr[i]) mq.push_back(i);
        mprev = r;
    endtask

    task automatic compare_model(input string tag);
        int exp_cnt;
        int exp_hid;
        exp_cnt = mq.size();
        exp_hid = (exp_cnt > 0) ? mq[0] : 0;
        check({tag, " count"},      int'(count),      exp_cnt);
        check({tag, " head_valid"}, int'(head_valid), (exp_cnt > 0) ? 1 : 0);
        check({tag, " head_id"},    int'(head_id),    exp_hid);
        check({tag, " head_req"},   int'(head_req),   (exp_cnt > 0) ? (1 << exp_hid) : 0);
        check({tag, " pending"},    int'(pending),    int'(model_pending()));
    endtask

    initial begin
        logic [3:0] cur_raw;
        logic [3:0] flip;
        logic       p;

        // Continues from queue {0,1,2,3} right after reset release with all lines high.
        tbl.push_back('{4'b1111, 1'b1, 3'd3, 2'd1, 4'b1110});
        tbl.push_back('{4'b0000, 1'b1, 3'd2, 2'd2, 4'b1100});
        tbl.push_back('{4'b0000, 1'b1, 3'd1, 2'd3, 4'b1000});
        tbl.push_back('{4'b0000, 1'b1, 3'd0, 2'd0, 4'b0000});
        // pop while empty
        tbl.push_back('{4'b0000, 1'b1, 3'd0, 2'd0, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 3'd0, 2'd0, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 3'd0, 2'd0, 4'b0000});
        // ordered arrival 2, 0, 3 then drain
        tbl.push_back('{4'b0100, 1'b0, 3'd1, 2'd2, 4'b0100});
        tbl.push_back('{4'b0101, 1'b0, 3'd2, 2'd2, 4'b0101});
        tbl.push_back('{4'b1101, 1'b0, 3'd3, 2'd2, 4'b1101});
        tbl.push_back('{4'b1101, 1'b1, 3'd2, 2'd0, 4'b1001});
        tbl.push_back('{4'b1101, 1'b1, 3'd1, 2'd3, 4'b1000});
        tbl.push_back('{4'b1101, 1'b1, 3'd0, 2'd0, 4'b0000});
        // queue {1}, then pop with requester 3 rising on the same edge
        tbl.push_back('{4'b0010, 1'b0, 3'd1, 2'd1, 4'b0010});
        tbl.push_back('{4'b1010, 1'b1, 3'd1, 2'd3, 4'b1000});
        // duplicate edge from a pending requester, then pop while held high
        tbl.push_back('{4'b1000, 1'b0, 3'd1, 2'd3, 4'b1000});
        tbl.push_back('{4'b1010, 1'b0, 3'd2, 2'd3, 4'b1010});
        tbl.push_back('{4'b1000, 1'b0, 3'd2, 2'd3, 4'b1010});
        tbl.push_back('{4'b1010, 1'b0, 3'd2, 2'd3, 4'b1010});
        tbl.push_back('{4'b1010, 1'b1, 3'd1, 2'd1, 4'b0010});
        tbl.push_back('{4'b1010, 1'b1, 3'd0, 2'd0, 4'b0000});
        tbl.push_back('{4'b1010, 1'b0, 3'd0, 2'd0, 4'b0000});
        // same requester popped and re-edged on one edge: arrival dropped
        tbl.push_back('{4'b0000, 1'b0, 3'd0, 2'd0, 4'b0000});
        tbl.push_back('{4'b1000, 1'b0, 3'd1, 2'd3, 4'b1000});
        tbl.push_back('{4'b0000, 1'b0, 3'd1, 2'd3, 4'b1000});
        tbl.push_back('{4'b1000, 1'b1, 3'd0, 2'd0, 4'b0000});
        tbl.push_back('{4'b0000, 1'b0, 3'd0, 2'd0, 4'b0000});

        // Reset held with every request line high.
        resetn  = 1'b0;
        raw_req = 4'b1111;
        pop     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_state("in_reset", 3'd0, 2'd0, 4'b0000);
        resetn = 1'b1;
        step(4'b1111, 1'b0);
        check_state("post_reset", 3'd4, 2'd0, 4'b1111);

        foreach (tbl[v]) begin
            step(tbl[v].raw, tbl[v].pop);
            check_state($sformatf("vec%0d", v), tbl[v].cnt, tbl[v].hid, tbl[v].pend);
        end

        // Withdraw behaviour: queue {0,2,3}, then drop requester 2, then 0.
        step(4'b1101, 1'b0);
        check_state("wd_fill", 3'd3, 2'd0, 4'b1101);
        step(4'b1001, 1'b0);
`ifdef REQ_WITHDRAW_EN
        check_state("wd_drop2", 3'd2, 2'd0, 4'b1001);
`else
        check_state("wd_drop2", 3'd3, 2'd0, 4'b1101);
`endif
        step(4'b1000, 1'b0);
`ifdef REQ_WITHDRAW_EN
        check_state("wd_drop0", 3'd1, 2'd3, 4'b1000);
`else
        check_state("wd_drop0", 3'd3, 2'd0, 4'b1101);
`endif

        // Asynchronous reset in the middle of a cycle clears the queue at once.
        #3;
        resetn = 1'b0;
        #1;
        check_state("async_reset", 3'd0, 2'd0, 4'b0000);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
        cur_raw = raw_req;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            flip = 4'b0000;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) flip[b] = 1'b1;
            cur_raw = cur_raw ^ flip;
            p = ($urandom_range(0, 2) == 0);
            step(cur_raw, p);
            model_step(cur_raw, p);
            compare_model($sformatf("rnd%0d", cyc));
            if ($urandom_range(0, 199) == 0) begin
                #2;
                resetn = 1'b0;
                #1;
                model_reset();
                compare_model($sformatf("rnd_rst%0d", cyc));
                @(posedge clk);
                #1;
                resetn = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/req_order_queue.md
# req_order_queue

Upstream ordering stage for the 4-requester grant arbiter. Detects rising edges on four raw request lines, records requester IDs in strict arrival order in a 4-entry queue, and presents the oldest pending requester as a one-hot request to the arbiter. The consumer pops the head when its service burst completes. The arbiter therefore sees requests in first-come-first-served order rather than fixed index order.

## Interface
- No parameters. Depth is fixed at 4, one entry per requester, and IDs are 2 bits.
- clk  in  1  system clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- raw_req  in  4  level request from requesters 0..3
- pop  in  1  consumer done with head entry; removes head at the next rising edge
- head_valid  out  1  queue non-empty
- head_id  out  2  requester ID of oldest entry; 0 when empty
- head_req  out  4  one-hot of head_id when head_valid, else 4'b0000; feeds arbiter request inputs
- pending  out  4  bit i set while requester i has an entry in the queue
- count  out  3  number of entries, 0..4

## Operation
- State:
  - prev_req[3:0], the raw_req sampled at the previous edge
  - slot[0..3] of 2-bit IDs, slot0 = head
  - pending[3:0]
  - count
- Arrival:
  - arr[i] = raw_req[i] & ~prev_req[i] & ~pending[i], where pending is the pre-update value.
  - An edge from a requester that is already pending is dropped and not remembered.
  - A requester held high after being popped is not re-queued. It must drop low and re-raise.
- Per-edge update order:
  1. Pop removes slot0 if pop & head_valid; the remaining slots shift one toward the head.
  2. Withdraw removal, only with REQ_WITHDRAW_EN.
  3. All arrivals of this edge are appended in ascending index order. Simultaneous arrivals tie-break lowest index first.
- pop while empty is ignored, with no state change.
- Overflow is impossible: at most one entry per requester, and depth is 4. count never exceeds 4.
- Pop and arrival of the same requester on the same edge: the arrival is evaluated against pre-pop pending, so it is dropped.
- Invariant: popcount(pending) == count, and slot IDs are unique.
- Unused slots (index ≥ count) hold 2'b00.
- All outputs derive combinationally from registers only. There is no combinational path from raw_req or pop to any output.

## Timing
- Reset (resetn low, asynchronous):
  - prev_req = 0, all slots = 0, pending = 0, count = 0.
  - Outputs: head_valid = 0, head_id = 0, head_req = 0, pending = 0, count = 0.
- Reset assertion mid-operation discards all queued entries immediately.
- After release, a raw_req already high counts as a rising edge at the first clock edge, because prev_req is 0.
- Arrival latency: a raw_req rising edge sampled at clock edge N appears in pending/count at N; head_req updates after N when the queue was empty.
- Pop latency: pop sampled at edge N removes the head at N; the new head is visible immediately after N.
- Pop and an arrival of a different requester on the same edge with count = 4 is legal. It is impossible anyway, since all four are pending.
- Back-to-back pops on consecutive cycles drain one entry per cycle.

## Configuration
- REQ_WITHDRAW_EN when defined:
  - At each edge, any queued entry whose raw_req bit is low is removed, including the head.
  - Remaining entries compact toward slot0 with relative order preserved.
  - Removal applies after pop and before arrivals.
  - Multiple withdrawals can occur on one edge.
- REQ_WITHDRAW_EN not defined:
  - Entries persist until popped, regardless of raw_req level.
  - No withdraw logic is compiled in.

## Test plan
- Reset: hold resetn low with raw_req = 4'b1111 → all outputs 0. Release → after first edge, count = 4, order 0,1,2,3, head_req = 4'b0001.
- Ordered arrival: raise raw_req[2], then [0] one cycle later, then [3] → head_id = 2. Pops yield IDs 2, 0, 3, then head_valid = 0, count = 0.
- Simultaneous pop and arrival: queue {1}, pop = 1 with raw_req[3] rising on the same edge → count = 1, head_id = 3, pending = 4'b1000.
- Duplicate and held request: requester 1 pending, toggle raw_req[1] low then high → count unchanged. Pop while raw_req[1] is held high → not re-queued, pending[1] = 0.
- Pop while empty: pop = 1 for 3 cycles with count = 0 → all outputs remain 0.
- REQ_WITHDRAW_EN: queue {0,2,3}, drop raw_req[2] → queue {0,3}, count = 2. Drop raw_req[0] → head_id = 3. Without the macro, the same stimulus leaves queue {0,2,3}.
